// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the generator
// to the pixel pipeline (text, cursor, overlay, DAC).
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             p_tick;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             line_start;
  logic             frame_start;

  modport master (
    output p_tick,
    output pixel_x,
    output pixel_y,
    output hsync,
    output vsync,
    output video_on,
    output line_start,
    output frame_start
  );

  modport slave (
    input p_tick,
    input pixel_x,
    input pixel_y,
    input hsync,
    input vsync,
    input video_on,
    input line_start,
    input frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with pixel divider,
// zero-lag registered syncs and line/frame start strobes.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 2,
  parameter int CNT_W     = 10
) (
  input logic              clk,
  input logic              rst,
  input logic              en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);

  localparam logic [CNT_W-1:0] H_VIS =
    CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS =
    CNT_W'(V_DISPLAY);

  localparam logic [CNT_W-1:0] HS_FIRST =
    CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST =
    CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST =
    CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST =
    CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic HS_ON = HSYNC_POL[0];
  localparam logic VS_ON = VSYNC_POL[0];

  localparam longint CNT_SPAN =
    longint'(1) << CNT_W;

  localparam bit PARAMS_OK =
    (CLK_DIV >= 1) &&
    (H_DISPLAY >= 1) && (H_FRONT >= 1) &&
    (H_SYNC >= 1) && (H_BACK >= 1) &&
    (V_DISPLAY >= 1) && (V_FRONT >= 1) &&
    (V_SYNC >= 1) && (V_BACK >= 1) &&
    (CNT_SPAN >= longint'(H_TOTAL)) &&
    (CNT_SPAN >= longint'(V_TOTAL));

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] y_d;
  logic             hs_q;
  logic             vs_q;
  logic             vo_q;
  logic             tick;
  logic             hs_act;
  logic             vs_act;
  logic             vo_act;

  // Pixel strobe: last clk of each divided pixel period.
  always_comb begin
    tick = en & ~rst & (div_q == DIV_LAST);
  end

  // Next divider and raster position, wrapping x then y.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (tick) begin
      if (x_q != H_LAST) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        if (y_q != V_LAST) begin
          y_d = y_q + 1'b1;
        end else begin
          y_d = '0;
        end
      end
    end
  end

  // Region decode of the next position so the registered
  // syncs line up with the counters they describe.
  always_comb begin
    hs_act = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
    vs_act = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
    vo_act = (x_d < H_VIS) && (y_d < V_VIS);
  end

  // State and registered outputs; en low freezes all of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      vo_q  <= 1'b0;
    end else if (en) begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_act ? HS_ON : ~HS_ON;
      vs_q  <= vs_act ? VS_ON : ~VS_ON;
      vo_q  <= vo_act;
    end
  end

  // Strobes are combinational on the tick so they stay one
  // clk wide whatever the divide ratio.
  always_comb begin
    vga.p_tick      = tick;
    vga.pixel_x     = x_q;
    vga.pixel_y     = y_q;
    vga.hsync       = hs_q;
    vga.vsync       = vs_q;
    vga.video_on    = vo_q;
    vga.line_start  = tick & (x_q == '0);
    vga.frame_start = tick & (x_q == '0) & (y_q == '0);
  end

  a_params: assert property (@(posedge clk) PARAMS_OK)
    else $error("vga_timing_gen: illegal parameters");

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four configurations checked against an
// elapsed-clock raster model, a vector table and corner sequences.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int hd, hf, hs, hb;
    int vd, vf, vs, vb;
    int hp, vp, dv;
  } cfg_t;

  typedef struct {
    int k;
    int x, y;
    bit hs, vs, vo, pt, ls, fs;
  } tv_t;

  logic   clk;
  logic   rst_v [4];
  logic   en_v  [4];
  obs_t   obs   [4];
  longint t     [4];
  bit     st    [4];
  longint ls_last [4];
  longint fs_last [4];
  int     hs_cnt  [4];
  int     vs_cnt  [4];
  longint cyc_n;
  int     n_vec;
  int     n_bad;
  tv_t    tv [12];

  vga_timing_gen_if #(.CNT_W(10)) if_a ();
  vga_timing_gen_if #(.CNT_W(10)) if_b ();
  vga_timing_gen_if #(.CNT_W(10)) if_c ();
  vga_timing_gen_if #(.CNT_W(10)) if_d ();

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .vga(if_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1), .CNT_W(10)
  ) u_b (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .vga(if_b)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(3), .CNT_W(10)
  ) u_c (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .vga(if_c)
  );

  vga_timing_gen #(
    .H_DISPLAY(40), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5),
    .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(2), .CNT_W(10)
  ) u_d (
    .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .vga(if_d)
  );

  assign obs[0] = {if_a.p_tick, if_a.pixel_x, if_a.pixel_y,
                   if_a.hsync, if_a.vsync, if_a.video_on,
                   if_a.line_start, if_a.frame_start};
  assign obs[1] = {if_b.p_tick, if_b.pixel_x, if_b.pixel_y,
                   if_b.hsync, if_b.vsync, if_b.video_on,
                   if_b.line_start, if_b.frame_start};
  assign obs[2] = {if_c.p_tick, if_c.pixel_x, if_c.pixel_y,
                   if_c.hsync, if_c.vsync, if_c.video_on,
                   if_c.line_start, if_c.frame_start};
  assign obs[3] = {if_d.p_tick, if_d.pixel_x, if_d.pixel_y,
                   if_d.hsync, if_d.vsync, if_d.video_on,
                   if_d.line_start, if_d.frame_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cfg_t cfg_of(int k);
    cfg_t c;
    case (k)
      0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
      1:       c = '{8, 2, 3, 1, 4, 1, 1, 1, 1, 1, 1};
      2:       c = '{8, 2, 3, 1, 4, 1, 1, 1, 1, 1, 3};
      default: c = '{40, 4, 6, 4, 30, 3, 2, 5, 0, 0, 2};
    endcase
    return c;
  endfunction

  // Position after tk enabled clks: pixel index = tk / divide.
  function automatic int mx(int k, longint tk);
    cfg_t c;
    int ht;
    c  = cfg_of(k);
    ht = c.hd + c.hf + c.hs + c.hb;
    return int'((tk / c.dv) % ht);
  endfunction

  function automatic int my(int k, longint tk);
    cfg_t c;
    int ht, vt;
    c  = cfg_of(k);
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    return int'(((tk / c.dv) / ht) % vt);
  endfunction

  function automatic obs_t exp_f(int k, bit e, bit r);
    cfg_t c;
    obs_t o;
    int   x, y;
    bit   hsa, vsa;
    c     = cfg_of(k);
    x     = mx(k, t[k]);
    y     = my(k, t[k]);
    hsa   = (x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs);
    vsa   = (y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs);
    o.pt  = e && !r && ((t[k] % c.dv) == longint'(c.dv - 1));
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.hs  = hsa ? c.hp[0] : !c.hp[0];
    o.vs  = vsa ? c.vp[0] : !c.vp[0];
    o.vo  = st[k] && (x < c.hd) && (y < c.vd);
    o.ls  = o.pt && (x == 0);
    o.fs  = o.ls && (y == 0);
    return o;
  endfunction

  task automatic chk(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Line/frame period and sync width measured between strobes.
  task automatic track(int k);
    cfg_t c;
    int   ht, vt;
    c  = cfg_of(k);
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    if (rst_v[k] || !en_v[k]) begin
      ls_last[k] = -1;
      fs_last[k] = -1;
      hs_cnt[k]  = 0;
      vs_cnt[k]  = 0;
    end else begin
      if (obs[k].ls === 1'b1) begin
        if (ls_last[k] >= 0) begin
          chk($sformatf("dut%0d line period", k),
              int'(cyc_n - ls_last[k]), ht * c.dv);
          chk($sformatf("dut%0d hsync clks", k),
              hs_cnt[k], c.hs * c.dv);
        end
        ls_last[k] = cyc_n;
        hs_cnt[k]  = 0;
      end
      if (obs[k].fs === 1'b1) begin
        if (fs_last[k] >= 0) begin
          chk($sformatf("dut%0d frame period", k),
              int'(cyc_n - fs_last[k]), ht * vt * c.dv);
          chk($sformatf("dut%0d vsync clks", k),
              vs_cnt[k], c.vs * ht * c.dv);
        end
        fs_last[k] = cyc_n;
        vs_cnt[k]  = 0;
      end
      if (obs[k].hs === c.hp[0]) hs_cnt[k]++;
      if (obs[k].vs === c.vp[0]) vs_cnt[k]++;
    end
  endtask

  // One clk: compare every DUT to the model, then advance it.
  task automatic cyc();
    obs_t e;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = exp_f(k, en_v[k], rst_v[k]);
      n_vec++;
      if (obs[k] !== e) begin
        n_bad++;
        $display("FAIL model dut%0d cyc%0d: pt=%b x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b want pt=%b x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b",
          k, cyc_n, obs[k].pt, obs[k].x, obs[k].y, obs[k].hs,
          obs[k].vs, obs[k].vo, obs[k].ls, obs[k].fs,
          e.pt, e.x, e.y, e.hs, e.vs, e.vo, e.ls, e.fs);
      end
      if (k != 2) track(k);
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rst_v[k]) begin
        t[k]  = 0;
        st[k] = 1'b0;
      end else if (en_v[k]) begin
        t[k]++;
        st[k] = 1'b1;
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    int  s;
    bit  found;
    bit  ok;
    n_vec = 0;
    n_bad = 0;
    cyc_n = 0;

    tv[0]  = '{0,  0,  0, 0, 0, 0, 1, 1, 1};
    tv[1]  = '{1,  1,  0, 0, 0, 1, 1, 0, 0};
    tv[2]  = '{8,  8,  0, 0, 0, 0, 1, 0, 0};
    tv[3]  = '{10, 10, 0, 1, 0, 0, 1, 0, 0};
    tv[4]  = '{12, 12, 0, 1, 0, 0, 1, 0, 0};
    tv[5]  = '{13, 13, 0, 0, 0, 0, 1, 0, 0};
    tv[6]  = '{14, 0,  1, 0, 0, 1, 1, 1, 0};
    tv[7]  = '{70, 0,  5, 0, 1, 0, 1, 1, 0};
    tv[8]  = '{81, 11, 5, 1, 1, 0, 1, 0, 0};
    tv[9]  = '{84, 0,  6, 0, 0, 0, 1, 1, 0};
    tv[10] = '{98, 0,  0, 0, 0, 1, 1, 1, 1};
    tv[11] = '{99, 1,  0, 0, 0, 1, 1, 0, 0};

    for (int k = 0; k < 4; k++) begin
      rst_v[k]   = 1'b1;
      en_v[k]    = 1'b1;
      t[k]       = 0;
      st[k]      = 1'b0;
      ls_last[k] = -1;
      fs_last[k] = -1;
      hs_cnt[k]  = 0;
      vs_cnt[k]  = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    cyc();
    cyc();
    #1;
    chk("rst pixel_x", int'(obs[0].x), 0);
    chk("rst pixel_y", int'(obs[0].y), 0);
    chk("rst hsync", int'(obs[0].hs), 1);
    chk("rst vsync", int'(obs[0].vs), 1);
    chk("rst video_on", int'(obs[0].vo), 0);

    for (int k = 0; k < 4; k++) rst_v[k] = 1'b0;

    // Small config, CLK_DIV=1: fixed expectations per clk count.
    for (int i = 0; i < 12; i++) begin
      while (t[1] < longint'(tv[i].k)) cyc();
      #1;
      ok = (int'(obs[1].x) == tv[i].x) &&
           (int'(obs[1].y) == tv[i].y) &&
           (obs[1].hs === tv[i].hs) &&
           (obs[1].vs === tv[i].vs) &&
           (obs[1].vo === tv[i].vo) &&
           (obs[1].pt === tv[i].pt) &&
           (obs[1].ls === tv[i].ls) &&
           (obs[1].fs === tv[i].fs);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL tbl%0d k=%0d: x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ls=%b fs=%b",
          i, tv[i].k, obs[1].x, obs[1].y, obs[1].hs, obs[1].vs,
          obs[1].vo, obs[1].pt, obs[1].ls, obs[1].fs,
          tv[i].x, tv[i].y, tv[i].hs, tv[i].vs, tv[i].vo,
          tv[i].pt, tv[i].ls, tv[i].fs);
      end
    end

    // en gating mid-pixel (divider=1) on the CLK_DIV=3 config.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if ((t[2] % 3) == 1 && mx(2, t[2]) >= 2 &&
          mx(2, t[2]) <= 6) begin
        found = 1'b1;
      end else begin
        cyc();
      end
    end
    chk("gate phase found", int'(found), 1);
    if (found) begin
      #1;
      s = int'(obs[2].x);
      en_v[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        cyc();
        #1;
        chk("gate hold x", int'(obs[2].x), s);
        chk("gate no tick",
            int'(obs[2].pt | obs[2].ls | obs[2].fs), 0);
      end
      en_v[2] = 1'b1;
      #1;
      chk("resume clk0 x", int'(obs[2].x), s);
      cyc();
      #1;
      chk("resume clk1 x", int'(obs[2].x), s);
      cyc();
      #1;
      chk("resume clk2 x", int'(obs[2].x), s + 1);
    end

    // Mid-frame reset at (9,3) on the CLK_DIV=1 config.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mx(1, t[1]) == 9 && my(1, t[1]) == 3) begin
        found = 1'b1;
      end else begin
        cyc();
      end
    end
    chk("rst point found", int'(found), 1);
    if (found) begin
      rst_v[1] = 1'b1;
      cyc();
      #1;
      chk("midrst x", int'(obs[1].x), 0);
      chk("midrst y", int'(obs[1].y), 0);
      chk("midrst hsync", int'(obs[1].hs), 0);
      chk("midrst vsync", int'(obs[1].vs), 0);
      chk("midrst video_on", int'(obs[1].vo), 0);
      rst_v[1] = 1'b0;
      cyc();
      #1;
      chk("restart x", int'(obs[1].x), 1);
      chk("restart y", int'(obs[1].y), 0);
      chk("restart video_on", int'(obs[1].vo), 1);
    end

    // Random enable and occasional reset on the divided config
    // while the other configs run whole lines and frames.
    while (cyc_n < 9800) begin
      en_v[2]  = ($urandom_range(0, 3) != 0);
      rst_v[2] = ($urandom_range(0, 399) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
